hazard_fwd_ctrl: RTL and testbench

- Hazard and forwarding controller for the 5-stage pipeline.
- Tracks destination and source register numbers of instructions in the EX, MEM and WB stages.
- Generates the 2-bit select codes for the EX-stage operand Mux4_32 instances, plus IF/ID stall and ID/EX bubble controls.
- Sits beside the ID stage; owns a busy counter for the multi-cycle multiply/divide unit.

---
 rtl/hazard_fwd_ctrl_pkg.sv | 36 +++
 rtl/hazard_fwd_ctrl_if.sv | 40 ++++
 rtl/hazard_fwd_ctrl_fwd_sel.sv | 26 ++
 rtl/hazard_fwd_ctrl.sv | 104 ++++++++++
 tb/tb_hazard_fwd_ctrl.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/hazard_fwd_ctrl_pkg.sv
// Shared types and constants for the hazard/forwarding controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package hazard_fwd_ctrl_pkg;

  // Register-number width is fixed here because the stage record below depends on it.
  localparam int REG_W      = 5;
  localparam int MD_LAT_DEF = 32;
  localparam int CNT_W_DEF  = 6;

  // EX operand mux select codes; 2'b11 is reserved and never driven.
  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  typedef logic [REG_W-1:0] reg_num_t;

  localparam reg_num_t REG_ZERO = '0;

  // Per-stage shadow of the instruction fields the controller cares about.
  typedef struct packed {
    reg_num_t dest;
    logic     we;
    logic     load;
    reg_num_t rs;
    reg_num_t rt;
  } stage_t;

  localparam stage_t STAGE_NOP = '0;

  // True when a stage writing 'dest' produces the value 'src' needs; $0 never matches.
  function automatic logic reg_hit(input logic we, input reg_num_t dest, input reg_num_t src);
    return we && (dest != REG_ZERO) && (dest == src);
  endfunction

endpackage

// File: rtl/hazard_fwd_ctrl_if.sv
// ID-side request and EX/stall control bundle of the hazard/forwarding controller.
// Latency: n/a (wires only).
// Backpressure: stall_if_id / bubble_id_ex returned to the pipeline; ext_stall freezes state.
// Ports: id_* describe the instruction in ID; branch_flush/ext_stall are pipeline controls;
//        fwd_*_sel, stall_if_id, bubble_id_ex, md_busy are controller outputs.
interface hazard_fwd_ctrl_if;
  import hazard_fwd_ctrl_pkg::*;

  reg_num_t   id_rs;
  reg_num_t   id_rt;
  logic       id_uses_rs;
  logic       id_uses_rt;
  reg_num_t   id_dest;
  logic       id_reg_write;
  logic       id_is_load;
  logic       id_md_start;
  logic       id_uses_hilo;
  logic       branch_flush;
  logic       ext_stall;
  logic [1:0] fwd_a_sel;
  logic [1:0] fwd_b_sel;
  logic       stall_if_id;
  logic       bubble_id_ex;
  logic       md_busy;

  // Pipeline side: presents the ID instruction, consumes the controls.
  modport master (
    output id_rs, id_rt, id_uses_rs, id_uses_rt, id_dest, id_reg_write,
           id_is_load, id_md_start, id_uses_hilo, branch_flush, ext_stall,
    input  fwd_a_sel, fwd_b_sel, stall_if_id, bubble_id_ex, md_busy
  );

  // Controller side.
  modport slave (
    input  id_rs, id_rt, id_uses_rs, id_uses_rt, id_dest, id_reg_write,
           id_is_load, id_md_start, id_uses_hilo, branch_flush, ext_stall,
    output fwd_a_sel, fwd_b_sel, stall_if_id, bubble_id_ex, md_busy
  );

endinterface

// File: rtl/hazard_fwd_ctrl_fwd_sel.sv
// Priority compare picking the EX operand source: MEM result, else WB result, else regfile.
// Latency: combinational.
// Backpressure: none.
// Ports: mem_*_i / wb_*_i are the writer shadows, src_i the EX source register, sel_o the mux code.
module fwd_sel_unit
  import hazard_fwd_ctrl_pkg::*;
(
  input  logic       mem_we_i,
  input  reg_num_t   mem_dest_i,
  input  logic       wb_we_i,
  input  reg_num_t   wb_dest_i,
  input  reg_num_t   src_i,
  output logic [1:0] sel_o
);

  // MEM is checked first: it holds the newer value when both stages write the same register.
  always_comb begin
    sel_o = FWD_RF;
    if (reg_hit(mem_we_i, mem_dest_i, src_i)) begin
      sel_o = FWD_MEM;
    end else if (reg_hit(wb_we_i, wb_dest_i, src_i)) begin
      sel_o = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_fwd_ctrl.sv
// Hazard and forwarding controller: EX operand selects, load-use / mult-div stalls, ID/EX bubbles.
// Latency: selects come from registered EX/MEM/WB shadows; stall/bubble are combinational from ID.
// Backpressure: ext_stall freezes shadows and busy counter; stall/bubble outputs are not gated by it.
// Ports: clk, rst_n (async active-low) plus the slave side of hazard_fwd_ctrl_if.
module hazard_fwd_ctrl
  import hazard_fwd_ctrl_pkg::*;
#(
  parameter int MD_LAT = MD_LAT_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  hazard_fwd_ctrl_if.slave  bus
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MD_LAT);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  stage_t           ex_q, ex_d;
  stage_t           mem_q, mem_d;
  stage_t           wb_q, wb_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  stage_t           id_stage;
  logic             luse;
  logic             mdh;
  logic             stall;
  logic             bubble;
  logic             md_accept;

  assign id_stage = '{dest: bus.id_dest, we: bus.id_reg_write, load: bus.id_is_load,
                      rs: bus.id_rs, rt: bus.id_rt};

  // A load in EX cannot forward in time to an ID consumer; $0 never counts.
  assign luse = ex_q.load && ex_q.we && (ex_q.dest != REG_ZERO) &&
                ((bus.id_uses_rs && (bus.id_rs == ex_q.dest)) ||
                 (bus.id_uses_rt && (bus.id_rt == ex_q.dest)));

  assign mdh    = (cnt_q != '0) && bus.id_uses_hilo;
  assign stall  = luse || mdh;
  assign bubble = luse || mdh || bus.branch_flush;

  // A start is only accepted when the instruction actually leaves ID.
  assign md_accept = bus.id_md_start && !stall && !bus.branch_flush;

  always_comb begin
    ex_d  = ex_q;
    mem_d = mem_q;
    wb_d  = wb_q;
    cnt_d = cnt_q;
    if (!bus.ext_stall) begin
      ex_d  = bubble ? STAGE_NOP : id_stage;
      mem_d = ex_q;
      wb_d  = mem_q;
      if (md_accept) begin
        cnt_d = CNT_LOAD;
      end else if (cnt_q != '0) begin
        cnt_d = cnt_q - CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q  <= STAGE_NOP;
      mem_q <= STAGE_NOP;
      wb_q  <= STAGE_NOP;
      cnt_q <= '0;
    end else begin
      ex_q  <= ex_d;
      mem_q <= mem_d;
      wb_q  <= wb_d;
      cnt_q <= cnt_d;
    end
  end

  fwd_sel_unit u_fwd_a (
    .mem_we_i   (mem_q.we),
    .mem_dest_i (mem_q.dest),
    .wb_we_i    (wb_q.we),
    .wb_dest_i  (wb_q.dest),
    .src_i      (ex_q.rs),
    .sel_o      (bus.fwd_a_sel)
  );

  fwd_sel_unit u_fwd_b (
    .mem_we_i   (mem_q.we),
    .mem_dest_i (mem_q.dest),
    .wb_we_i    (wb_q.we),
    .wb_dest_i  (wb_q.dest),
    .src_i      (ex_q.rt),
    .sel_o      (bus.fwd_b_sel)
  );

  assign bus.stall_if_id  = stall;
  assign bus.bubble_id_ex = bubble;
  assign bus.md_busy      = (cnt_q != '0);

  // Later-stage fields kept for debug visibility but not needed by any decision.
  logic unused_shadow;
  assign unused_shadow = ^{mem_q.load, mem_q.rs, mem_q.rt, wb_q.load, wb_q.rs, wb_q.rt,
                           ex_q.rs[0] & 1'b0};

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
module tb_hazard_fwd_ctrl;
  import hazard_fwd_ctrl_pkg::*;

  logic clk;
  logic rst_n;
  int   errs;
  int   checks;

  hazard_fwd_ctrl_if bus();

  hazard_fwd_ctrl #(.MD_LAT(4), .CNT_W(6)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present an instruction in ID.
  task automatic set_id(input int rs, input int rt, input logic urs, input logic urt,
                        input int dest, input logic we, input logic ld,
                        input logic md, input logic hilo);
    bus.id_rs        = reg_num_t'(rs);
    bus.id_rt        = reg_num_t'(rt);
    bus.id_uses_rs   = urs;
    bus.id_uses_rt   = urt;
    bus.id_dest      = reg_num_t'(dest);
    bus.id_reg_write = we;
    bus.id_is_load   = ld;
    bus.id_md_start  = md;
    bus.id_uses_hilo = hilo;
  endtask

  task automatic set_nop();
    set_id(0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    set_nop();
    repeat (3) tick();
  endtask

  task automatic chk_ctl(input string tag, input logic st, input logic bb);
    #1;
    chk({tag, ".stall"}, {3'b0, bus.stall_if_id}, {3'b0, st});
    chk({tag, ".bubble"}, {3'b0, bus.bubble_id_ex}, {3'b0, bb});
  endtask

  task automatic chk_sel(input string tag, input logic [1:0] a, input logic [1:0] b);
    #1;
    chk({tag, ".fwd_a"}, {2'b0, bus.fwd_a_sel}, {2'b0, a});
    chk({tag, ".fwd_b"}, {2'b0, bus.fwd_b_sel}, {2'b0, b});
  endtask

  initial begin
    errs   = 0;
    checks = 0;
    rst_n  = 1'b0;
    bus.branch_flush = 1'b0;
    bus.ext_stall    = 1'b0;
    set_nop();

    // Reset state
    #3;
    chk_sel("rst", FWD_RF, FWD_RF);
    chk_ctl("rst", 1'b0, 1'b0);
    chk("rst.md_busy", {3'b0, bus.md_busy}, 4'h0);
    tick();
    rst_n = 1'b1;
    tick();

    // Back-to-back ALU: add $3,$1,$2 ; sub $4,$3,$5
    set_id(1, 2, 1'b1, 1'b1, 3, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    set_id(3, 5, 1'b1, 1'b1, 4, 1'b1, 1'b0, 1'b0, 1'b0);
    chk_ctl("b2b", 1'b0, 1'b0);
    tick();
    set_nop();
    chk_sel("b2b", FWD_MEM, FWD_RF);
    drain();

    // One-gap dependency: add $3 ; nop ; or $6,$3,$3
    set_id(1, 2, 1'b1, 1'b1, 3, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    set_nop();
    tick();
    set_id(3, 3, 1'b1, 1'b1, 6, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    set_nop();
    chk_sel("gap1", FWD_WB, FWD_WB);
    drain();

    // Both MEM and WB write $3: MEM wins
    set_id(1, 2, 1'b1, 1'b1, 3, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    set_id(1, 2, 1'b1, 1'b1, 3, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    set_id(3, 3, 1'b1, 1'b1, 9, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    set_nop();
    chk_sel("prio", FWD_MEM, FWD_MEM);
    drain();

    // Load-use: lw $2,0($1) ; add $7,$2,$1
    set_id(1, 0, 1'b1, 1'b0, 2, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    set_id(2, 1, 1'b1, 1'b1, 7, 1'b1, 1'b0, 1'b0, 1'b0);
    chk_ctl("luse.c0", 1'b1, 1'b1);
    tick();
    chk_ctl("luse.c1", 1'b0, 1'b0);
    tick();
    set_nop();
    chk_sel("luse.ex", FWD_WB, FWD_RF);
    drain();

    // $0 writer: lw $0 ; use of $0
    set_id(1, 0, 1'b1, 1'b0, 0, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    set_id(0, 0, 1'b1, 1'b1, 5, 1'b1, 1'b0, 1'b0, 1'b0);
    chk_ctl("zero", 1'b0, 1'b0);
    tick();
    set_nop();
    chk_sel("zero", FWD_RF, FWD_RF);
    drain();

    // Branch flush together with load-use, then alone
    set_id(1, 0, 1'b1, 1'b0, 2, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    set_id(2, 1, 1'b1, 1'b1, 7, 1'b1, 1'b0, 1'b0, 1'b0);
    bus.branch_flush = 1'b1;
    chk_ctl("flush+luse", 1'b1, 1'b1);
    tick();
    chk_ctl("flush", 1'b0, 1'b1);
    tick();
    // Flushed instruction reached EX as a NOP: nothing forwards
    bus.branch_flush = 1'b0;
    set_nop();
    chk_sel("flush.ex", FWD_RF, FWD_RF);
    drain();

    // A flushed mult must not start the busy counter
    set_id(4, 5, 1'b1, 1'b1, 0, 1'b0, 1'b0, 1'b1, 1'b1);
    bus.branch_flush = 1'b1;
    tick();
    bus.branch_flush = 1'b0;
    set_nop();
    #1;
    chk("flush.md", {3'b0, bus.md_busy}, 4'h0);
    drain();

    // Mult/div (MD_LAT=4): mult at t0, mfhi from t1
    set_id(4, 5, 1'b1, 1'b1, 0, 1'b0, 1'b0, 1'b1, 1'b1);
    chk_ctl("md.t0", 1'b0, 1'b0);
    tick();
    set_id(0, 0, 1'b0, 1'b0, 8, 1'b1, 1'b0, 1'b0, 1'b1);
    #1;
    chk("md.t1.busy", {3'b0, bus.md_busy}, 4'h1);
    chk_ctl("md.t1", 1'b1, 1'b1);
    tick();
    chk_ctl("md.t2", 1'b1, 1'b1);
    tick();
    chk_ctl("md.t3", 1'b1, 1'b1);
    tick();
    chk_ctl("md.t4", 1'b1, 1'b1);
    tick();
    chk_ctl("md.t5", 1'b0, 1'b0);
    chk("md.t5.busy", {3'b0, bus.md_busy}, 4'h0);
    drain();

    // Freeze: ext_stall held 3 cycles while a MEM forward is in EX
    set_id(1, 2, 1'b1, 1'b1, 3, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    set_id(3, 5, 1'b1, 1'b1, 4, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    set_nop();
    bus.ext_stall = 1'b1;
    chk_sel("frz.c0", FWD_MEM, FWD_RF);
    tick();
    chk_sel("frz.c1", FWD_MEM, FWD_RF);
    tick();
    chk_sel("frz.c2", FWD_MEM, FWD_RF);
    tick();
    chk_sel("frz.c3", FWD_MEM, FWD_RF);
    bus.ext_stall = 1'b0;
    tick();
    chk_sel("frz.rel", FWD_RF, FWD_RF);
    drain();

    // Reset pulsed mid load-use stall, with mult/div busy too
    set_id(4, 5, 1'b1, 1'b1, 0, 1'b0, 1'b0, 1'b1, 1'b1);
    tick();
    set_id(1, 0, 1'b1, 1'b0, 2, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    set_id(2, 1, 1'b1, 1'b1, 7, 1'b1, 1'b0, 1'b0, 1'b0);
    chk_ctl("rst2.pre", 1'b1, 1'b1);
    rst_n = 1'b0;
    chk_ctl("rst2", 1'b0, 1'b0);
    chk("rst2.md_busy", {3'b0, bus.md_busy}, 4'h0);
    chk_sel("rst2", FWD_RF, FWD_RF);
    rst_n = 1'b1;
    tick();
    chk_ctl("rst2.post", 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
